pulse_bin_to_bcd: RTL

- Sequential binary-to-BCD converter (shift-add-3 / double-dabble), one input bit per clock.
- Sits directly upstream of the 7-segment sweep driver and converts pulse-generator parameter values (period, width, delay counts) into packed decimal digits.
- Output BCD word is held stable between conversions, so the sweeper can sample it asynchronously to the conversion rate.

---
 rtl/pulse_disp_pkg.sv | 34 +++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/pulse_bin_to_bcd.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pulse_disp_pkg.sv
// ---------------------------------------------------------------------------
// pulse_disp_pkg
//
// Shared definitions for the pulse-generator display path.
//   IN_W    : width of the binary parameter values (period, width, delay)
//   DIGITS  : number of BCD digits shown on the 7-segment sweep
//   BCD_MAX : largest value representable in DIGITS decimal digits
//   state_t : conversion FSM states
//   bcd_limit() : 10^digits - 1, usable in constant expressions
// ---------------------------------------------------------------------------
package pulse_disp_pkg;

    localparam int IN_W   = 20;
    localparam int DIGITS = 6;

    // 10^digits - 1, evaluated at elaboration time for saturation limits.
    function automatic longint unsigned bcd_limit(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam longint unsigned BCD_MAX = bcd_limit(DIGITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
//
// Combinational double-dabble correction for a single BCD nibble: a digit of
// 5 or more gets 3 added so that the following left shift carries correctly
// into the next decimal digit.
//   digit_in  : current BCD digit (0..9 in normal operation)
//   digit_out : corrected digit, 4 bits, no carry out
// ---------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Inputs are always 0..9, so the result stays within 4 bits (max 12).
    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/pulse_bin_to_bcd.sv
// ---------------------------------------------------------------------------
// pulse_bin_to_bcd
//
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Feeds the 7-segment sweep driver; bcd_out/ovf are only updated when a
// conversion completes, so the sweeper may sample them at any time.
//
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : conversion request, sampled only while idle
//   bin_in   : unsigned binary value, captured on the accepting edge
//   busy     : high while shifting
//   done     : one-cycle pulse when bcd_out/ovf have just been updated
//   bcd_out  : packed BCD, digit k in [4k+3:4k]
//   ovf      : last input exceeded 10^DIGITS-1 and was saturated
// ---------------------------------------------------------------------------
module pulse_bin_to_bcd #(
    parameter int IN_W   = pulse_disp_pkg::IN_W,
    parameter int DIGITS = pulse_disp_pkg::DIGITS
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [IN_W-1:0]     bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                ovf
);

    import pulse_disp_pkg::*;

    localparam int                 BCD_W    = 4 * DIGITS;
    localparam int                 CNT_W    = $clog2(IN_W + 1);
    localparam longint unsigned    LIMIT    = bcd_limit(DIGITS);
    localparam logic [IN_W-1:0]    SAT_VAL  = IN_W'(LIMIT);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(IN_W - 1);

    state_t              state_q, state_d;
    logic [IN_W-1:0]     bin_q, bin_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;

    logic [BCD_W-1:0]      adj_acc;
    logic [BCD_W+IN_W-1:0] shift_all;

    // Per-digit add-3 correction applied before every shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (acc_q[4*k +: 4]),
            .digit_out (adj_acc[4*k +: 4])
        );
    end

    // {accumulator, binary} shifted left by one after correction.
    assign shift_all = {adj_acc[BCD_W-2:0], bin_q, 1'b0};

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Saturating up front keeps every digit within 0..9,
                    // so the add-3 step can never overflow a nibble.
                    if (64'(bin_in) > LIMIT) begin
                        bin_d  = SAT_VAL;
                        pend_d = 1'b1;
                    end else begin
                        bin_d  = bin_in;
                        pend_d = 1'b0;
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shift_all[BCD_W+IN_W-1:IN_W];
                bin_d = shift_all[IN_W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FINISH;
                    bcd_d   = shift_all[BCD_W+IN_W-1:IN_W];
                    ovf_d   = pend_q;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == FINISH);
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule
